// File: rtl/key_expansion.sv
`default_nettype none
// ============================================================================
// Module   : key_expansion_sbox
// Purpose  : AES forward S-box for one byte, computed as the GF(2^8)
//            multiplicative inverse (x^254, so 0 maps to 0) followed by the
//            AES affine transform.
// Ports    : i_data  - input byte
//            o_data  - substituted byte
// Revision : 1.0 - initial release
// ============================================================================
module key_expansion_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ acc;
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    logic [7:0] w_x2, w_x3, w_x12, w_x15, w_x240, w_inv;

    // Addition chain for x^254: 2,3,12,15,240,252,254
    always_comb begin
        w_x2   = gfMul(i_data, i_data);
        w_x3   = gfMul(w_x2, i_data);
        w_x12  = gfMul(gfMul(w_x3, w_x3), gfMul(w_x3, w_x3));
        w_x15  = gfMul(w_x12, w_x3);
        w_x240 = gfMul(gfMul(gfMul(w_x15, w_x15), gfMul(w_x15, w_x15)),
                       gfMul(gfMul(w_x15, w_x15), gfMul(w_x15, w_x15)));
        w_x240 = gfMul(w_x240, w_x240);
        w_inv  = gfMul(gfMul(w_x240, w_x12), w_x2);
    end

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    assign o_data = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// ============================================================================
// Module   : key_expansion
// Purpose  : Iterative AES-128 key schedule. Captures a cipher key on start,
//            derives round keys 1..10 at one per clock into an 11-entry
//            register file, and serves them through a registered read port.
// Ports    : CLK       - clock, rising edge
//            RST       - asynchronous active-high reset
//            start     - expansion request (ignored while busy)
//            keyIn     - 128-bit cipher key, w0 = keyIn[127:96]
//            busy      - expansion in progress
//            keysValid - all 11 round keys stored
//            rdAddr    - round-key index 0..10
//            rdKey     - round key for the previous cycle's rdAddr, else 0
// Revision : 1.0 - initial release
// ============================================================================
module key_expansion (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [127:0] keyIn,
    output logic         busy,
    output logic         keysValid,
    input  logic [3:0]   rdAddr,
    output logic [127:0] rdKey
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_workKey;
    logic [127:0] r_slot [0:10];

    logic [31:0]  w_rotWord;
    logic [31:0]  w_subWord;
    logic [7:0]   w_rcon;
    logic [31:0]  w_temp;
    logic [31:0]  w_w0n, w_w1n, w_w2n, w_w3n;
    logic [127:0] w_nextKey;
    logic         w_startOk;

    assign w_rotWord = {r_workKey[23:0], r_workKey[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            key_expansion_sbox u_sbox (
                .i_data (w_rotWord[8*gi +: 8]),
                .o_data (w_subWord[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        case (r_cnt)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_temp    = w_subWord ^ {w_rcon, 24'h000000};
    assign w_w0n     = r_workKey[127:96] ^ w_temp;
    assign w_w1n     = r_workKey[95:64]  ^ w_w0n;
    assign w_w2n     = r_workKey[63:32]  ^ w_w1n;
    assign w_w3n     = r_workKey[31:0]   ^ w_w2n;
    assign w_nextKey = {w_w0n, w_w1n, w_w2n, w_w3n};

    assign w_startOk = start && (r_state != EXPAND);

    // Control and read port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            busy      <= 1'b0;
            keysValid <= 1'b0;
            rdKey     <= 128'd0;
        end else begin
            case (r_state)
                EXPAND: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        keysValid <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        r_state   <= EXPAND;
                        r_cnt     <= 4'd1;
                        busy      <= 1'b1;
                        keysValid <= 1'b0;
                    end
                end
            endcase

            if (keysValid && (rdAddr <= 4'd10)) begin
                rdKey <= r_slot[rdAddr];
            end else begin
                rdKey <= 128'd0;
            end
        end
    end

    // Key storage carries no reset: contents are hidden while keysValid is low,
    // and writes are gated by the reset-cleared state.
    always_ff @(posedge CLK) begin
        if (w_startOk) begin
            r_workKey <= keyIn;
            r_slot[0] <= keyIn;
        end else if (r_state == EXPAND) begin
            r_workKey     <= w_nextKey;
            r_slot[r_cnt] <= w_nextKey;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_expansion.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_expansion
// Purpose  : Self-checking bench for key_expansion. Read requests push the
//            expected rdKey into a scoreboard queue; a monitor pops and
//            compares one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_expansion;

    localparam logic [127:0] c_FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_ZERO0  = 128'h0;
    localparam logic [127:0] c_ZERO1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [127:0] keyIn;
    logic         busy;
    logic         keysValid;
    logic [3:0]   rdAddr;
    logic [127:0] rdKey;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int           due;
        logic [127:0] exp;
        logic [3:0]   addr;
    } exp_t;

    exp_t sbq[$];
    exp_t monEntry;

    key_expansion dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .keyIn     (keyIn),
        .busy      (busy),
        .keysValid (keysValid),
        .rdAddr    (rdAddr),
        .rdKey     (rdKey)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the read port answers one cycle after the address is sampled
    always @(posedge CLK) begin
        #1;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            monEntry = sbq.pop_front();
            check($sformatf("rdKey[addr=%0d]", monEntry.addr), rdKey, monEntry.exp);
        end
    end

    // Called right after a falling edge; returns after the next falling edge.
    task automatic readPush(input logic [3:0] a, input logic [127:0] exp);
        exp_t e;
        rdAddr = a;
        e.due  = cyc + 1;
        e.exp  = exp;
        e.addr = a;
        sbq.push_back(e);
        @(negedge CLK);
    endtask

    task automatic runExpansion(input logic [127:0] key, input bit midStart, input string lbl);
        start = 1'b1;
        keyIn = key;
        @(negedge CLK);              // E0 has passed
        start = 1'b0;
        keyIn = ~key;                // key must have been captured at E0 only
        for (int k = 0; k <= 9; k++) begin
            check($sformatf("%s busy after E%0d", lbl, k), {127'd0, busy}, 128'd1);
            check($sformatf("%s keysValid after E%0d", lbl, k), {127'd0, keysValid}, 128'd0);
            if (midStart && k == 4) begin
                start = 1'b1;        // lands on E5, must be ignored
                keyIn = c_ZERO0;
            end
            if (k == 5) start = 1'b0;
            @(negedge CLK);
        end
        check($sformatf("%s busy after E10", lbl), {127'd0, busy}, 128'd0);
        check($sformatf("%s keysValid after E10", lbl), {127'd0, keysValid}, 128'd1);
    endtask

    initial begin
        RST    = 1'b1;
        start  = 1'b0;
        keyIn  = 128'd0;
        rdAddr = 4'd0;
        repeat (3) @(negedge CLK);
        check("reset busy", {127'd0, busy}, 128'd0);
        check("reset keysValid", {127'd0, keysValid}, 128'd0);
        check("reset rdKey", rdKey, 128'd0);
        RST = 1'b0;
        @(negedge CLK);
        for (int a = 0; a < 16; a++) readPush(a[3:0], 128'd0);
        check("idle keysValid", {127'd0, keysValid}, 128'd0);

        // FIPS-197 key
        runExpansion(c_FIPS0, 1'b0, "fips");
        readPush(4'd0, c_FIPS0);
        readPush(4'd1, c_FIPS1);
        readPush(4'd10, c_FIPS10);

        // Read boundary, back to back
        readPush(4'd10, c_FIPS10);
        readPush(4'd11, 128'd0);
        readPush(4'd15, 128'd0);
        readPush(4'd0, c_FIPS0);

        // Restart from DONE with the all-zero key
        runExpansion(c_ZERO0, 1'b0, "zero");
        readPush(4'd1, c_ZERO1);
        readPush(4'd10, c_ZERO10);
        readPush(4'd0, c_ZERO0);

        // FIPS run with an ignored zero-key start at E5
        runExpansion(c_FIPS0, 1'b1, "midstart");
        readPush(4'd0, c_FIPS0);
        readPush(4'd1, c_FIPS1);
        readPush(4'd10, c_FIPS10);

        // Reset pulse around E4 of a zero-key run
        start = 1'b1;
        keyIn = c_ZERO0;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async reset busy", {127'd0, busy}, 128'd0);
        check("async reset keysValid", {127'd0, keysValid}, 128'd0);
        check("async reset rdKey", rdKey, 128'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        check("post-reset busy", {127'd0, busy}, 128'd0);
        check("post-reset keysValid", {127'd0, keysValid}, 128'd0);
        readPush(4'd0, 128'd0);

        runExpansion(c_FIPS0, 1'b0, "after-reset");
        readPush(4'd0, c_FIPS0);
        readPush(4'd1, c_FIPS1);
        readPush(4'd10, c_FIPS10);

        for (int w = 0; w < 5 && sbq.size() > 0; w++) @(negedge CLK);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
